sr_bank_writer: RTL and testbench

- Write-side driver for a bank of WIDTH SR flip-flops.
- Accepts a target word over a valid/ready handshake and tracks the bank contents in a shadow register.
- Emits per-bit Set/Reset excitation (S = T & ~shadow, R = ~T & shadow) for one cycle, waits for the bank to settle, then checks the read-back value.
- It is the command-generating end of the SR-ff interface: the SR-ff turns S/R into state; this block turns a desired state into S/R.

---
 rtl/sr_bank_writer_pkg.sv | 20 ++
 rtl/sr_settle_counter.sv | 34 +++
 rtl/sr_bank_writer.sv | 129 ++++++++++++
 tb/tb_sr_bank_writer.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/sr_bank_writer_pkg.sv
// Shared definitions for the SR-flip-flop bank writer: FSM encoding,
// per-bit excitation helper and parameter limits.
package sr_bank_writer_pkg;

   localparam int SETTLE_MIN = 1;

   typedef enum logic [2:0] {
      ST_CLEAR  = 3'd0,
      ST_IDLE   = 3'd1,
      ST_DRIVE  = 3'd2,
      ST_SETTLE = 3'd3,
      ST_CHECK  = 3'd4
   } state_e;

   // Returns {S, R} for one bit: set only on a 0->1 change, reset only on 1->0.
   function automatic logic [1:0] sr_excite(input logic target, input logic shadow);
      return {target & ~shadow, ~target & shadow};
   endfunction

endpackage

// File: rtl/sr_settle_counter.sv
// Down-counter that times the settle window after an SR excitation pulse.
module sr_settle_counter #(
   parameter int W = 2
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         load_i,
   input  logic [W-1:0] load_val_i,
   input  logic         dec_i,
   output logic         zero_o
);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load_i)
         cnt_d = load_val_i;
      else if (dec_i && (cnt_q != '0))
         cnt_d = cnt_q - W'(1);
   end

   // NOTE: state registers take non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i)
         cnt_q <= '0;
      else
         cnt_q <= cnt_d;
   end

   assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/sr_bank_writer.sv
// Turns a requested bank word into one-cycle S/R excitation, waits for the
// bank to settle and verifies the read-back, keeping a shadow of the bank.
module sr_bank_writer
   import sr_bank_writer_pkg::*;
#(
   parameter int WIDTH  = 8,
   parameter int SETTLE = 2
) (
   input  logic             Clk,
   input  logic             Rst,
   input  logic             wr_valid,
   input  logic [WIDTH-1:0] wr_data,
   output logic             wr_ready,
   output logic [WIDTH-1:0] S,
   output logic [WIDTH-1:0] R,
   input  logic [WIDTH-1:0] Q_fb,
   output logic             done,
   output logic             err
);

   localparam int CNT_W = $clog2(SETTLE) + 1;

   if (SETTLE < SETTLE_MIN) begin : g_settle_check
      $error("sr_bank_writer: SETTLE must be at least 1");
   end

   state_e           state_q, state_d;
   logic [WIDTH-1:0] s_q, s_d, r_q, r_d;
   logic [WIDTH-1:0] shadow_q, shadow_d, target_q, target_d;
   logic             ready_q, ready_d, done_q, done_d, err_q, err_d;
   logic             cnt_load, cnt_dec, cnt_zero;

   sr_settle_counter #(.W(CNT_W)) u_settle (
      .clk_i      (Clk),
      .rst_i      (Rst),
      .load_i     (cnt_load),
      .load_val_i (CNT_W'(SETTLE - 1)),
      .dec_i      (cnt_dec),
      .zero_o     (cnt_zero)
   );

   // Outputs are registered from the next state, so they line up with state_q.
   // NOTE: every combinational output gets a default first so no latch is inferred.
   always_comb begin
      state_d  = state_q;
      s_d      = '0;
      r_d      = '0;
      ready_d  = 1'b0;
      done_d   = 1'b0;
      err_d    = 1'b0;
      shadow_d = shadow_q;
      target_d = target_q;
      cnt_load = 1'b0;
      cnt_dec  = 1'b0;
      unique case (state_q)
         ST_CLEAR: begin
            // r_q is zero out of reset, so the all-ones clear pulse lasts one cycle.
            if (r_q == {WIDTH{1'b1}}) begin
               state_d = ST_IDLE;
               ready_d = 1'b1;
            end else begin
               r_d = {WIDTH{1'b1}};
            end
         end
         ST_IDLE: begin
            if (wr_valid && ready_q) begin
               state_d  = ST_DRIVE;
               target_d = wr_data;
               for (int i = 0; i < WIDTH; i++)
                  {s_d[i], r_d[i]} = sr_excite(wr_data[i], shadow_q[i]);
            end else begin
               ready_d = 1'b1;
            end
         end
         ST_DRIVE: begin
            state_d  = ST_SETTLE;
            cnt_load = 1'b1;
         end
         ST_SETTLE: begin
            if (cnt_zero) begin
               state_d = ST_CHECK;
               done_d  = 1'b1;
               if (Q_fb == target_q) begin
                  shadow_d = target_q;
               end else begin
                  err_d    = 1'b1;
                  shadow_d = Q_fb;
               end
            end else begin
               cnt_dec = 1'b1;
            end
         end
         ST_CHECK: begin
            state_d = ST_IDLE;
            ready_d = 1'b1;
         end
         default: state_d = ST_CLEAR;
      endcase
   end

   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         state_q  <= ST_CLEAR;
         s_q      <= '0;
         r_q      <= '0;
         ready_q  <= 1'b0;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
         shadow_q <= '0;
         target_q <= '0;
      end else begin
         state_q  <= state_d;
         s_q      <= s_d;
         r_q      <= r_d;
         ready_q  <= ready_d;
         done_q   <= done_d;
         err_q    <= err_d;
         shadow_q <= shadow_d;
         target_q <= target_d;
      end
   end

   assign S        = s_q;
   assign R        = r_q;
   assign wr_ready = ready_q;
   assign done     = done_q;
   assign err      = err_q;

endmodule

// File: tb/tb_sr_bank_writer.sv
// Directed bench for sr_bank_writer with a behavioural SR-bank model on Q_fb.
module tb_sr_bank_writer;

   localparam int W      = 8;
   localparam int SETTLE = 2;

   logic         Clk = 1'b0;
   logic         Rst = 1'b1;
   logic         wr_valid = 1'b0;
   logic [W-1:0] wr_data = '0;
   logic         wr_ready, done, err;
   logic [W-1:0] S, R, Q_fb;
   logic [W-1:0] bank  = 8'h5A;
   logic [W-1:0] stuck = 8'h00;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [7:0] data;
      logic [7:0] stuck;
      logic [7:0] exp_s;
      logic [7:0] exp_r;
      logic       exp_err;
      logic [7:0] exp_q;
   } vec_t;

   vec_t vecs[8];

   sr_bank_writer #(.WIDTH(W), .SETTLE(SETTLE)) dut (
      .Clk      (Clk),
      .Rst      (Rst),
      .wr_valid (wr_valid),
      .wr_data  (wr_data),
      .wr_ready (wr_ready),
      .S        (S),
      .R        (R),
      .Q_fb     (Q_fb),
      .done     (done),
      .err      (err)
   );

   always #5 Clk = ~Clk;

   // SR bank: set wins nothing here because S&R must never overlap; stuck bits read 0.
   always @(posedge Clk) bank <= ((bank & ~R) | S) & ~stuck;
   assign Q_fb = bank;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time expired");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Waits (bounded) for wr_ready, presents d, and returns on the negedge of the DRIVE cycle.
   task automatic start_write(input logic [7:0] d);
      int n = 0;
      while (1) begin
         @(negedge Clk);
         if (wr_ready) break;
         n++;
         if (n > 20) begin
            check("ready_timeout", 8'(wr_ready), 8'h01);
            break;
         end
      end
      wr_valid = 1'b1;
      wr_data  = d;
      @(posedge Clk);
      @(negedge Clk);
      wr_valid = 1'b0;
      wr_data  = ~d;
   endtask

   initial begin
      int acc, ovl;
      vecs[0] = '{8'hA5, 8'h00, 8'hA5, 8'h00, 1'b0, 8'hA5};
      vecs[1] = '{8'h3C, 8'h00, 8'h18, 8'h81, 1'b0, 8'h3C};
      vecs[2] = '{8'h3C, 8'h00, 8'h00, 8'h00, 1'b0, 8'h3C};
      vecs[3] = '{8'h01, 8'h01, 8'h01, 8'h3C, 1'b1, 8'h00};
      vecs[4] = '{8'h01, 8'h01, 8'h01, 8'h00, 1'b1, 8'h00};
      vecs[5] = '{8'h01, 8'h00, 8'h01, 8'h00, 1'b0, 8'h01};
      vecs[6] = '{8'hFF, 8'h00, 8'hFE, 8'h00, 1'b0, 8'hFF};
      vecs[7] = '{8'h00, 8'h00, 8'h00, 8'hFF, 1'b0, 8'h00};

      // Reset state, CLEAR pulse and first wr_ready.
      #1;
      check("rst_S", S, 8'h00);
      check("rst_R", R, 8'h00);
      check("rst_ready", 8'(wr_ready), 8'h00);
      check("rst_done", 8'(done), 8'h00);
      repeat (2) @(negedge Clk);
      Rst = 1'b0;
      @(negedge Clk);
      check("clear_R", R, 8'hFF);
      check("clear_S", S, 8'h00);
      check("clear_ready", 8'(wr_ready), 8'h00);
      @(negedge Clk);
      check("idle_ready", 8'(wr_ready), 8'h01);
      check("idle_R", R, 8'h00);
      check("clear_bank", Q_fb, 8'h00);

      foreach (vecs[v]) begin
         stuck = vecs[v].stuck;
         start_write(vecs[v].data);
         check($sformatf("v%0d_S", v), S, vecs[v].exp_s);
         check($sformatf("v%0d_R", v), R, vecs[v].exp_r);
         check($sformatf("v%0d_SandR", v), S & R, 8'h00);
         check($sformatf("v%0d_busy", v), 8'(wr_ready), 8'h00);
         for (int i = 0; i < SETTLE; i++) begin
            @(negedge Clk);
            check($sformatf("v%0d_settle%0d_SR", v, i), S | R, 8'h00);
            check($sformatf("v%0d_settle%0d_done", v, i), 8'(done), 8'h00);
         end
         @(negedge Clk);
         check($sformatf("v%0d_done", v), 8'(done), 8'h01);
         check($sformatf("v%0d_err", v), 8'(err), 8'(vecs[v].exp_err));
         check($sformatf("v%0d_bank", v), Q_fb, vecs[v].exp_q);
         @(negedge Clk);
         check($sformatf("v%0d_done_clr", v), 8'(done), 8'h00);
         check($sformatf("v%0d_ready", v), 8'(wr_ready), 8'h01);
      end
      stuck = 8'h00;

      // wr_valid held high: acceptances only every SETTLE+3 cycles.
      acc = 0;
      ovl = 0;
      wr_valid = 1'b1;
      wr_data  = 8'h3C;
      for (int i = 0; i < 3 * (SETTLE + 3); i++) begin
         if (wr_ready) acc++;
         if ((S & R) != 8'h00) ovl++;
         @(negedge Clk);
      end
      wr_valid = 1'b0;
      check("bp_accepts", 8'(acc), 8'd3);
      check("bp_overlap", 8'(ovl), 8'd0);
      check("bp_bank", Q_fb, 8'h3C);

      // Reset asserted mid-DRIVE clears excitation without waiting for a clock.
      start_write(8'hFF);
      check("rstd_S_before", S, 8'hC3);
      #2 Rst = 1'b1;
      #1;
      check("rstd_S", S, 8'h00);
      check("rstd_R", R, 8'h00);
      check("rstd_ready", 8'(wr_ready), 8'h00);
      @(negedge Clk);
      Rst = 1'b0;
      @(negedge Clk);
      check("rstd_clear_R", R, 8'hFF);
      @(negedge Clk);
      check("rstd_ready_back", 8'(wr_ready), 8'h01);
      check("rstd_bank", Q_fb, 8'h00);

      // Reset mid-SETTLE discards the word; CLEAR empties the bank again.
      start_write(8'hFF);
      check("rsts_S", S, 8'hFF);
      @(negedge Clk);
      #2 Rst = 1'b1;
      #1;
      check("rsts_done", 8'(done), 8'h00);
      check("rsts_SR", S | R, 8'h00);
      repeat (3) begin
         @(negedge Clk);
         check("rsts_hold_done", 8'(done), 8'h00);
      end
      Rst = 1'b0;
      @(negedge Clk);
      check("rsts_clear_R", R, 8'hFF);
      check("rsts_clear_S", S, 8'h00);
      @(negedge Clk);
      check("rsts_bank", Q_fb, 8'h00);
      check("rsts_ready", 8'(wr_ready), 8'h01);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
